commit_result_queue: RTL and testbench

//  Decoupling queue between execute_stage and the commit/ROB-writeback logic. Captures the two

---
 rtl/commit_result_queue_if.sv | 49 ++++
 rtl/commit_result_queue.sv | 125 ++++++++++++
 tb/tb_commit_result_queue.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/commit_result_queue_if.sv
// Shared execute->commit result types and the queue handshake interface.
// Pair-entry lanes travel as execute_to_commit_bus_t.
package commit_result_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        exc;
  } execute_to_commit_bus_t;
endpackage

interface commit_result_queue_if;
  import commit_result_pkg::*;

  logic                   flush;
  execute_to_commit_bus_t exe_bus1;
  execute_to_commit_bus_t exe_bus2;
  logic                   result_allowin;
  logic                   commit_valid;
  logic                   commit_ready;
  execute_to_commit_bus_t commit_bus1;
  execute_to_commit_bus_t commit_bus2;
  logic                   overflow_err;

  modport master (
    output flush,
    output exe_bus1,
    output exe_bus2,
    input  result_allowin,
    input  commit_valid,
    output commit_ready,
    input  commit_bus1,
    input  commit_bus2,
    input  overflow_err
  );

  modport slave (
    input  flush,
    input  exe_bus1,
    input  exe_bus2,
    output result_allowin,
    output commit_valid,
    input  commit_ready,
    output commit_bus1,
    output commit_bus2,
    output overflow_err
  );
endinterface

// File: rtl/commit_result_queue.sv
// Pair-entry result queue between execute_stage and commit.
// Optional same-cycle bypass when empty: define COMMIT_RESULT_BYPASS_EN.
module commit_result_queue
  import commit_result_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                 clk,
  input logic                 reset,
  commit_result_queue_if.slave cq
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = CNT_W - 1;

  execute_to_commit_bus_t mem1 [DEPTH];
  execute_to_commit_bus_t mem2 [DEPTH];

  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             ovf;

  execute_to_commit_bus_t lane1;
  execute_to_commit_bus_t lane2;
  execute_to_commit_bus_t head1;
  execute_to_commit_bus_t head2;

  logic empty;
  logic full;
  logic push_en;
  logic pop_en;
  logic byp;
  logic byp_take;
  logic do_wr;
  logic do_rd;
  logic ovf_set;
  logic [CNT_W:0] need;

  // Invalid lanes are zeroed so stale payload never reaches commit.
  assign lane1 = cq.exe_bus1.valid ? cq.exe_bus1 : '0;
  assign lane2 = cq.exe_bus2.valid ? cq.exe_bus2 : '0;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  assign push_en = (cq.exe_bus1.valid | cq.exe_bus2.valid)
                 & ~cq.flush;

  assign head1 = empty ? '0 : mem1[rptr];
  assign head2 = empty ? '0 : mem2[rptr];

`ifdef COMMIT_RESULT_BYPASS_EN
  assign byp = empty & push_en & reset;

  always_comb begin
    cq.commit_valid = (~empty | byp) & ~cq.flush;
    cq.commit_bus1  = head1;
    cq.commit_bus2  = head2;
    if (byp) begin
      cq.commit_bus1 = lane1;
      cq.commit_bus2 = lane2;
    end
  end
`else
  assign byp = 1'b0;

  always_comb begin
    cq.commit_valid = ~empty;
    cq.commit_bus1  = head1;
    cq.commit_bus2  = head2;
  end
`endif

  assign pop_en   = cq.commit_valid & cq.commit_ready & ~cq.flush;
  assign byp_take = byp & cq.commit_ready;
  assign do_rd    = pop_en & ~empty;
  assign do_wr    = push_en & ~byp_take & (~full | do_rd);
  assign ovf_set  = push_en & full & ~pop_en;

  // Headroom of two pairs: one already issued, one in execute now.
  assign need = {1'b0, count} + (CNT_W+1)'(push_en);
  assign cq.result_allowin = (need <= (CNT_W+1)'(DEPTH - 2));

  assign cq.overflow_err = ovf;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
      ovf   <= 1'b0;
    end else if (cq.flush) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      unique case (1'b1)
        (do_wr & ~do_rd): count <= count + 1'b1;
        (do_rd & ~do_wr): count <= count - 1'b1;
        default:          count <= count;
      endcase
      if (ovf_set) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && do_wr) begin
      mem1[wptr] <= lane1;
      mem2[wptr] <= lane2;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!ovf_set)
        else $warning("commit_result_queue: push dropped, queue full");
    end
  end
`endif

endmodule

// File: tb/tb_commit_result_queue.sv
// Directed scoreboard bench for commit_result_queue.
// Expected pairs are queued at push time and checked at pop time.
module tb_commit_result_queue;
  import commit_result_pkg::*;

  typedef execute_to_commit_bus_t bus_t;
  typedef struct {
    bus_t l1;
    bus_t l2;
  } pair_t;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  pair_t sb [$];
  logic  m_ovf;

  commit_result_queue_if cq ();

  commit_result_queue #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .cq    (cq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bus_t mk(input logic v, input logic [7:0] tag);
    bus_t b;
    b.valid  = v;
    b.pc     = 32'h1000_0000 | {24'h0, tag};
    b.rd     = tag[4:0];
    b.result = {tag, ~tag, tag ^ 8'h5a, 8'hc3};
    b.exc    = tag[0];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input bus_t b1, input bus_t b2,
                      input logic fl, input logic rdy);
    logic push, byp, ev, popped, consumed;
    bus_t e1, e2, h1, h2;
    int   n;
    @(negedge clk);
    cq.exe_bus1     = b1;
    cq.exe_bus2     = b2;
    cq.flush        = fl;
    cq.commit_ready = rdy;
    #1;
    n    = sb.size();
    push = (b1.valid | b2.valid) & ~fl;
    e1   = b1.valid ? b1 : '0;
    e2   = b2.valid ? b2 : '0;
    byp  = 1'b0;
`ifdef COMMIT_RESULT_BYPASS_EN
    byp  = push && (n == 0);
    ev   = ((n > 0) || byp) && !fl;
`else
    ev   = (n > 0);
`endif
    h1 = '0;
    h2 = '0;
    if (n > 0) begin
      h1 = sb[0].l1;
      h2 = sb[0].l2;
    end else if (byp) begin
      h1 = e1;
      h2 = e2;
    end
    chk("commit_valid", 128'(cq.commit_valid), 128'(ev));
    chk("commit_bus1", 128'(cq.commit_bus1), 128'(h1));
    chk("commit_bus2", 128'(cq.commit_bus2), 128'(h2));
    chk("result_allowin", 128'(cq.result_allowin),
        128'((n + int'(push)) <= 2));
    popped   = ev && rdy && !fl;
    consumed = 1'b0;
    if (popped) begin
      if (n > 0) void'(sb.pop_front());
      else consumed = 1'b1;
    end
    if (push && !consumed) begin
      if (n == 4 && !popped) m_ovf = 1'b1;
      else sb.push_back('{e1, e2});
    end
    if (fl) sb.delete();
    @(posedge clk);
    #1;
    chk("overflow_err", 128'(cq.overflow_err), 128'(m_ovf));
    chk("count", 128'(dut.count), 128'(sb.size()));
  endtask

  bus_t idle;

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_ovf       = 1'b0;
    idle        = mk(1'b0, 8'hee);

    // reset held two cycles while execute presents a valid lane
    reset           = 1'b0;
    cq.flush        = 1'b0;
    cq.commit_ready = 1'b0;
    cq.exe_bus1     = mk(1'b1, 8'h01);
    cq.exe_bus2     = idle;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_commit_valid", 128'(cq.commit_valid), 128'(0));
    chk("rst_count", 128'(dut.count), 128'(0));
    chk("rst_allowin", 128'(cq.result_allowin), 128'(1));
    chk("rst_overflow", 128'(cq.overflow_err), 128'(0));
    chk("rst_bus1", 128'(cq.commit_bus1), 128'(0));
    @(negedge clk);
    reset       = 1'b1;
    cq.exe_bus1 = idle;

    // ordered pairs A,B,C then drain
    step(mk(1, 8'h10), mk(1, 8'h11), 0, 0);
    step(mk(1, 8'h20), mk(1, 8'h21), 0, 0);
    step(mk(1, 8'h30), mk(1, 8'h31), 0, 0);
    repeat (3) step(idle, idle, 0, 1);
    step(idle, idle, 0, 1);

    // fill, overflow drop, then push+pop while full
    for (int i = 0; i < 4; i++)
      step(mk(1, 8'h40 + 8'(i)), mk(1, 8'h50 + 8'(i)), 0, 0);
    step(mk(1, 8'h44), mk(1, 8'h54), 0, 0);
    step(mk(1, 8'h45), mk(1, 8'h55), 0, 1);
    repeat (4) step(idle, idle, 0, 1);
    step(idle, idle, 0, 0);

    // flush with a concurrent push and ready
    for (int i = 0; i < 3; i++)
      step(mk(1, 8'h60 + 8'(i)), mk(1, 8'h70 + 8'(i)), 0, 0);
    step(mk(1, 8'h63), mk(1, 8'h73), 1, 1);
    step(idle, idle, 0, 1);

    // lane 2 only: lane 1 payload must read back as zero
    step(mk(0, 8'h81), mk(1, 8'h82), 0, 0);
    step(idle, idle, 0, 1);

    // empty queue, push with ready high
    step(mk(1, 8'h90), mk(1, 8'h91), 0, 1);
    step(idle, idle, 0, 1);
    step(idle, idle, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
